// File: rtl/main_pkg.sv
// rtl/main_pkg.sv - shared types, lamp encodings, segment codes and duration bounds for the traffic light controller
package main_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_CONFIG = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    typedef enum logic {
        SEL_GREEN  = 1'b0,
        SEL_YELLOW = 1'b1
    } sel_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [6:0] G_MIN = 7'd1;
    localparam logic [6:0] G_MAX = 7'd90;
    localparam logic [6:0] Y_MIN = 7'd1;
    localparam logic [6:0] Y_MAX = 7'd9;

    function automatic logic [2:0] road1_lamp(input phase_t ph);
        case (ph)
            PH0:     return LAMP_GREEN;
            PH1:     return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] road2_lamp(input phase_t ph);
        case (ph)
            PH2:     return LAMP_GREEN;
            PH3:     return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] units_of(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low {g,f,e,d,c,b,a} segments, 4'hF and other codes blank
module seg7_decoder
    import main_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/main.sv
// rtl/main.sv - two-road traffic light controller with AUTO/MANUAL/CONFIG modes; BUTTON_DEBOUNCE_EN adds 16-sample debounce
module main
    import main_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int DEF_GREEN  = 5,
    parameter int DEF_YELLOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buttonChangeMode,
    input  logic       buttonConfig,
    input  logic       buttonChangeLight,
    input  logic       buttonIncreaseTime,
    input  logic       buttonDecreaseTime,
    input  logic       buttonConfirm,
    output logic [6:0] led7_1,
    output logic [6:0] led7_2,
    output logic [6:0] led7_3,
    output logic [6:0] led7_4,
    output logic [2:0] led1,
    output logic [2:0] led2
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Button vector order doubles as the action priority, MSB highest.
    logic [5:0] w_btn;
    logic [5:0] w_level;
    logic [5:0] w_rise;
    logic [5:0] r_prev;

    assign w_btn = {buttonConfig, buttonChangeMode, buttonChangeLight,
                    buttonConfirm, buttonIncreaseTime, buttonDecreaseTime};

`ifdef BUTTON_DEBOUNCE_EN
    logic [5:0] r_stable;
    logic [3:0] r_dbc [6];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < 6; i++) r_dbc[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_btn[i] == r_stable[i]) begin
                    r_dbc[i] <= '0;
                end else if (r_dbc[i] == 4'd15) begin
                    r_stable[i] <= w_btn[i];
                    r_dbc[i]    <= '0;
                end else begin
                    r_dbc[i] <= r_dbc[i] + 4'd1;
                end
            end
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = w_btn;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_prev <= '0;
        else       r_prev <= w_level;
    end

    assign w_rise = w_level & ~r_prev;

    logic w_evt_cfg, w_evt_mode, w_evt_light, w_evt_conf, w_evt_inc, w_evt_dec;

    always_comb begin
        w_evt_cfg   = 1'b0;
        w_evt_mode  = 1'b0;
        w_evt_light = 1'b0;
        w_evt_conf  = 1'b0;
        w_evt_inc   = 1'b0;
        w_evt_dec   = 1'b0;
        if      (w_rise[5]) w_evt_cfg   = 1'b1;
        else if (w_rise[4]) w_evt_mode  = 1'b1;
        else if (w_rise[3]) w_evt_light = 1'b1;
        else if (w_rise[2]) w_evt_conf  = 1'b1;
        else if (w_rise[1]) w_evt_inc   = 1'b1;
        else if (w_rise[0]) w_evt_dec   = 1'b1;
    end

    mode_t      r_mode;
    phase_t     r_phase;
    sel_t       r_sel;
    logic [6:0] r_g, r_y, r_sg, r_sy, r_cnt1, r_cnt2;
    logic [DW-1:0] r_div;

    function automatic logic [6:0] lamp_dur(input logic [2:0] lamp,
                                            input logic [6:0] g,
                                            input logic [6:0] y);
        case (lamp)
            LAMP_RED:    return g + y;
            LAMP_YELLOW: return y;
            default:     return g;
        endcase
    endfunction

    phase_t w_next_phase;
    logic   w_tick, w_hit1, w_hit2, w_div_clr;

    assign w_next_phase = phase_t'(r_phase + 2'd1);
    assign w_tick       = (r_div == DW'(TICK_DIV - 1));
    assign w_hit1       = (r_cnt1 == 7'd1);
    assign w_hit2       = (r_cnt2 == 7'd1);
    assign w_div_clr    = w_evt_cfg | (w_evt_mode & (r_mode != MODE_CONFIG));

    always_ff @(posedge clk) begin
        if (reset || w_div_clr || w_tick) r_div <= '0;
        else                              r_div <= r_div + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= MODE_AUTO;
            r_phase <= PH0;
            r_sel   <= SEL_GREEN;
            r_g     <= 7'(DEF_GREEN);
            r_y     <= 7'(DEF_YELLOW);
            r_sg    <= 7'(DEF_GREEN);
            r_sy    <= 7'(DEF_YELLOW);
            r_cnt1  <= 7'(DEF_GREEN);
            r_cnt2  <= 7'(DEF_GREEN + DEF_YELLOW);
        end else begin
            case (r_mode)
                MODE_AUTO, MODE_MANUAL: begin
                    if (w_evt_cfg) begin
                        r_mode <= MODE_CONFIG;
                        r_sg   <= r_g;
                        r_sy   <= r_y;
                        r_sel  <= SEL_GREEN;
                    end else if (w_evt_mode && r_mode == MODE_AUTO) begin
                        r_mode <= MODE_MANUAL;
                    end else if (w_evt_mode) begin
                        r_mode  <= MODE_AUTO;
                        r_phase <= PH0;
                        r_cnt1  <= r_g;
                        r_cnt2  <= r_g + r_y;
                    end else if (r_mode == MODE_MANUAL) begin
                        if (w_evt_light) r_phase <= w_next_phase;
                    end else if (w_tick) begin
                        // The two roads change light at different phase boundaries.
                        if (w_hit1 || w_hit2) r_phase <= w_next_phase;
                        r_cnt1 <= w_hit1 ? lamp_dur(road1_lamp(w_next_phase), r_g, r_y)
                                         : r_cnt1 - 7'd1;
                        r_cnt2 <= w_hit2 ? lamp_dur(road2_lamp(w_next_phase), r_g, r_y)
                                         : r_cnt2 - 7'd1;
                    end
                end
                MODE_CONFIG: begin
                    if (w_evt_cfg) begin
                        r_mode  <= MODE_AUTO;
                        r_phase <= PH0;
                        r_cnt1  <= r_g;
                        r_cnt2  <= r_g + r_y;
                    end else if (w_evt_light) begin
                        r_sel <= (r_sel == SEL_GREEN) ? SEL_YELLOW : SEL_GREEN;
                    end else if (w_evt_conf) begin
                        r_g <= r_sg;
                        r_y <= r_sy;
                    end else if (w_evt_inc) begin
                        if (r_sel == SEL_GREEN && r_sg < G_MAX) r_sg <= r_sg + 7'd1;
                        if (r_sel == SEL_YELLOW && r_sy < Y_MAX) r_sy <= r_sy + 7'd1;
                    end else if (w_evt_dec) begin
                        if (r_sel == SEL_GREEN && r_sg > G_MIN) r_sg <= r_sg - 7'd1;
                        if (r_sel == SEL_YELLOW && r_sy > Y_MIN) r_sy <= r_sy - 7'd1;
                    end
                end
                default: r_mode <= MODE_AUTO;
            endcase
        end
    end

    logic [3:0] w_dig1, w_dig2, w_dig3, w_dig4;
    logic [6:0] w_edit;

    assign w_edit = (r_sel == SEL_YELLOW) ? r_sy : r_sg;

    always_comb begin
        led1   = road1_lamp(r_phase);
        led2   = road2_lamp(r_phase);
        w_dig1 = DIGIT_BLANK;
        w_dig2 = DIGIT_BLANK;
        w_dig3 = DIGIT_BLANK;
        w_dig4 = DIGIT_BLANK;
        case (r_mode)
            MODE_AUTO: begin
                w_dig1 = tens_of(r_cnt1);
                w_dig2 = units_of(r_cnt1);
                w_dig3 = tens_of(r_cnt2);
                w_dig4 = units_of(r_cnt2);
            end
            MODE_CONFIG: begin
                led1   = (r_sel == SEL_YELLOW) ? LAMP_YELLOW : LAMP_GREEN;
                led2   = LAMP_OFF;
                w_dig1 = tens_of(w_edit);
                w_dig2 = units_of(w_edit);
                w_dig3 = (r_sel == SEL_YELLOW) ? 4'd2 : 4'd1;
            end
            default: ;
        endcase
    end

    seg7_decoder u_seg1 (.i_digit(w_dig1), .o_seg(led7_1));
    seg7_decoder u_seg2 (.i_digit(w_dig2), .o_seg(led7_2));
    seg7_decoder u_seg3 (.i_digit(w_dig3), .o_seg(led7_3));
    seg7_decoder u_seg4 (.i_digit(w_dig4), .o_seg(led7_4));

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - directed self-checking bench for the traffic light controller with a one-cycle tick
module tb_main;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic b_mode = 1'b0, b_cfg = 1'b0, b_light = 1'b0;
    logic b_inc = 1'b0, b_dec = 1'b0, b_conf = 1'b0;
    logic [6:0] led7_1, led7_2, led7_3, led7_4;
    logic [2:0] led1, led2;
    logic [27:0] disp;
    int total = 0;
    int bad = 0;

    localparam int P_CFG = 0, P_MODE = 1, P_LIGHT = 2, P_CONF = 3, P_INC = 4, P_DEC = 5;

    main #(.TICK_DIV(1), .DEF_GREEN(5), .DEF_YELLOW(2)) dut (
        .clk(clk),
        .reset(reset),
        .buttonChangeMode(b_mode),
        .buttonConfig(b_cfg),
        .buttonChangeLight(b_light),
        .buttonIncreaseTime(b_inc),
        .buttonDecreaseTime(b_dec),
        .buttonConfirm(b_conf),
        .led7_1(led7_1),
        .led7_2(led7_2),
        .led7_3(led7_3),
        .led7_4(led7_4),
        .led1(led1),
        .led2(led2)
    );

    always #5 clk = ~clk;
    assign disp = {led7_1, led7_2, led7_3, led7_4};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {b_mode, b_cfg, b_light, b_inc, b_dec, b_conf} = '0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic press(input int which);
        case (which)
            P_CFG:   b_cfg = 1'b1;
            P_MODE:  b_mode = 1'b1;
            P_LIGHT: b_light = 1'b1;
            P_CONF:  b_conf = 1'b1;
            P_INC:   b_inc = 1'b1;
            default: b_dec = 1'b1;
        endcase
        step(1);
        {b_mode, b_cfg, b_light, b_inc, b_dec, b_conf} = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({led1, led2} !== {3'b001, 3'b100}) begin
            $display("FAIL reset_lamps got=%b_%b want=001_100", led1, led2); bad++;
        end
        total++;
        if (disp !== {7'h40, 7'h12, 7'h40, 7'h78}) begin
            $display("FAIL reset_digits got=%h want=%h", disp, {7'h40, 7'h12, 7'h40, 7'h78}); bad++;
        end
        step(5);
        total++;
        if ({led1, led2} !== {3'b010, 3'b100}) begin
            $display("FAIL tick5_lamps got=%b_%b want=010_100", led1, led2); bad++;
        end
        total++;
        if (disp !== {7'h40, 7'h24, 7'h40, 7'h24}) begin
            $display("FAIL tick5_digits got=%h want=%h", disp, {7'h40, 7'h24, 7'h40, 7'h24}); bad++;
        end
    endtask

    task automatic test_auto_cycle();
        do_reset();
        step(7);
        total++;
        if ({led1, led2, disp} !== {3'b100, 3'b001, 7'h40, 7'h78, 7'h40, 7'h12}) begin
            $display("FAIL tick7_p2 got=%b_%b_%h want=100_001 digits 0,7,0,5", led1, led2, disp); bad++;
        end
        step(5);
        total++;
        if ({led1, led2, disp} !== {3'b100, 3'b010, 7'h40, 7'h24, 7'h40, 7'h24}) begin
            $display("FAIL tick12_p3 got=%b_%b_%h want=100_010 digits 0,2,0,2", led1, led2, disp); bad++;
        end
        step(2);
        total++;
        if ({led1, led2, disp} !== {3'b001, 3'b100, 7'h40, 7'h12, 7'h40, 7'h78}) begin
            $display("FAIL tick14_p0 got=%b_%b_%h want=001_100 digits 0,5,0,7", led1, led2, disp); bad++;
        end
    endtask

    task automatic test_manual();
        do_reset();
        step(2);
        press(P_MODE);
        total++;
        if ({led1, disp} !== {3'b001, {4{7'h7F}}}) begin
            $display("FAIL manual_enter got=%b_%h want=001 blank", led1, disp); bad++;
        end
        step(3);
        press(P_LIGHT);
        total++;
        if ({led1, led2, disp} !== {3'b010, 3'b100, {4{7'h7F}}}) begin
            $display("FAIL manual_p1 got=%b_%b_%h want=010_100 blank", led1, led2, disp); bad++;
        end
        step(1);
        press(P_LIGHT);
        total++;
        if ({led1, led2} !== {3'b100, 3'b001}) begin
            $display("FAIL manual_p2 got=%b_%b want=100_001", led1, led2); bad++;
        end
        press(P_MODE);
        total++;
        if ({led1, led2, disp} !== {3'b001, 3'b100, 7'h40, 7'h12, 7'h40, 7'h78}) begin
            $display("FAIL manual_exit got=%b_%b_%h want=001_100 digits 0,5,0,7", led1, led2, disp); bad++;
        end
        step(1);
        total++;
        if (disp !== {7'h40, 7'h19, 7'h40, 7'h02}) begin
            $display("FAIL manual_resume got=%h want=%h", disp, {7'h40, 7'h19, 7'h40, 7'h02}); bad++;
        end
    endtask

    task automatic test_config_commit();
        do_reset();
        press(P_CFG);
        total++;
        if ({led1, led2, disp} !== {3'b001, 3'b000, 7'h40, 7'h12, 7'h79, 7'h7F}) begin
            $display("FAIL cfg_enter got=%b_%b_%h want=001_000 40,12,79,7F", led1, led2, disp); bad++;
        end
        press(P_INC);
        total++;
        if (disp !== {7'h40, 7'h02, 7'h79, 7'h7F}) begin
            $display("FAIL cfg_green_inc got=%h want=%h", disp, {7'h40, 7'h02, 7'h79, 7'h7F}); bad++;
        end
        press(P_LIGHT);
        total++;
        if ({led1, led2, disp} !== {3'b010, 3'b000, 7'h40, 7'h24, 7'h24, 7'h7F}) begin
            $display("FAIL cfg_sel_yellow got=%b_%b_%h want=010_000 40,24,24,7F", led1, led2, disp); bad++;
        end
        press(P_INC);
        press(P_CONF);
        press(P_CFG);
        total++;
        if ({led1, disp} !== {3'b001, 7'h40, 7'h02, 7'h40, 7'h10}) begin
            $display("FAIL cfg_commit got=%b_%h want=001 digits 0,6,0,9", led1, disp); bad++;
        end
        step(6);
        total++;
        if ({led1, disp} !== {3'b010, 7'h40, 7'h30, 7'h40, 7'h30}) begin
            $display("FAIL cfg_new_green_len got=%b_%h want=010 digits 0,3,0,3", led1, disp); bad++;
        end
    endtask

    task automatic test_config_bounds();
        do_reset();
        press(P_CFG);
        for (int i = 0; i < 5; i++) begin
            press(P_DEC);
            step(1);
        end
        total++;
        if (disp[27:14] !== {7'h40, 7'h79}) begin
            $display("FAIL green_floor got=%h want=4079", disp[27:14]); bad++;
        end
        press(P_LIGHT);
        for (int i = 0; i < 8; i++) begin
            press(P_INC);
            step(1);
        end
        total++;
        if (disp[27:14] !== {7'h40, 7'h10}) begin
            $display("FAIL yellow_ceiling got=%h want=4010", disp[27:14]); bad++;
        end
        press(P_CFG);
        total++;
        if (disp !== {7'h40, 7'h12, 7'h40, 7'h78}) begin
            $display("FAIL discard_edits got=%h want=%h", disp, {7'h40, 7'h12, 7'h40, 7'h78}); bad++;
        end
        step(1);
        press(P_CFG);
        press(P_INC);
        do_reset();
        press(P_CFG);
        total++;
        if (disp[27:14] !== {7'h40, 7'h12}) begin
            $display("FAIL reset_discards_cfg got=%h want=4012", disp[27:14]); bad++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        b_cfg = 1'b1;
        b_inc = 1'b1;
        step(1);
        {b_cfg, b_inc} = '0;
        step(1);
        total++;
        if ({led2, disp} !== {3'b000, 7'h40, 7'h12, 7'h79, 7'h7F}) begin
            $display("FAIL cfg_plus_inc got=%b_%h want=000 40,12,79,7F", led2, disp); bad++;
        end
        press(P_CFG);
        b_mode = 1'b1;
        b_light = 1'b1;
        step(1);
        {b_mode, b_light} = '0;
        total++;
        if ({led1, led2, disp} !== {3'b001, 3'b100, {4{7'h7F}}}) begin
            $display("FAIL mode_beats_light got=%b_%b_%h want=001_100 blank", led1, led2, disp); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_auto_cycle();
        test_manual();
        test_config_commit();
        test_config_bounds();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameters SHALL be: TICK_DIV, 1, clk cycles per 1-s countdown tick (board: 50000000); DEF_GREEN, 5, reset green time in s; DEF_YELLOW, 2, reset yellow time in s.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 buttonChangeMode  in  1  toggles AUTO/MANUAL.
REQ-005 buttonConfig  in  1  enters or leaves CONFIG.
REQ-006 buttonChangeLight  in  1  advances phase (MANUAL) or edit selection (CONFIG).
REQ-007 buttonIncreaseTime / buttonDecreaseTime  in  1 each  adjust edited duration (CONFIG only).
REQ-008 buttonConfirm  in  1  commits edited durations (CONFIG only).
REQ-009 led7_1, led7_2, led7_3, led7_4  out  7 each  seven-segment digits, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 led1, led2  out  3 each  road 1 / road 2 lamps, bit order {red,yellow,green}, active-high, exactly one bit set except in CONFIG.

Function
REQ-011 Buttons SHALL be sampled on clk and rising-edge detected; one action per press; a press SHALL be held at least one clk period to be guaranteed.
REQ-012 Simultaneous edges SHALL be resolved by priority Config > ChangeMode > ChangeLight > Confirm > Increase > Decrease; one action per cycle.
REQ-013 Modes SHALL be AUTO, MANUAL, CONFIG; Config from AUTO/MANUAL -> CONFIG; Config in CONFIG -> AUTO; ChangeMode toggles AUTO<->MANUAL and is ignored in CONFIG.
REQ-014 Active durations G (1..90) and Y (1..9) SHALL hold; red R = G+Y.
REQ-015 Phases: P0 {led1 green, led2 red}, P1 {yellow, red}, P2 {red, green}, P3 {red, yellow}; cycle P0->P1->P2->P3->P0.
REQ-016 AUTO: each road SHALL keep a remaining-seconds counter loaded with its current light's duration on every light change, decrement per tick, and change light on the tick at which it equals 1; road1 sequence G,Y,R and road2 R,G,Y stay aligned (period 2G+2Y).
REQ-017 AUTO display: led7_1/led7_2 = tens/units of road1 counter, led7_3/led7_4 = road2 counter; leading zero shown.
REQ-018 MANUAL: counters frozen, all digits blank (7'h7F); ChangeLight advances one phase immediately.
REQ-019 Entering AUTO from MANUAL or CONFIG SHALL restart at P0 with counters G and R.
REQ-020 CONFIG: shadow copies of G,Y loaded on entry; selection starts GREEN; ChangeLight toggles GREEN<->YELLOW; Increase/Decrease adjust selected shadow by 1, saturating at bounds.
REQ-021 Confirm SHALL copy shadows to active G,Y; leaving CONFIG without Confirm discards edits.
REQ-022 CONFIG outputs: led1 = selected colour bit, led2 = 3'b000; led7_1/led7_2 = edited value; led7_3 = 1 (GREEN) or 2 (YELLOW); led7_4 blank.
REQ-023 Digit codes: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex).
REQ-024 Tick divider SHALL cleared on every mode change and phase restart.

Reset
REQ-025 Reset SHALL force AUTO, P0, G=DEF_GREEN, Y=DEF_YELLOW, counters 5 and 7, led1=3'b001, led2=3'b100, digits 0,5,0,7, edge detectors cleared; reset mid-CONFIG discards edits.

Configuration
REQ-026 With BUTTON_DEBOUNCE_EN defined, a button SHALL be accepted only after 16 consecutive stable samples; without it, REQ-011 single-sample edge detection applies.

Structure
REQ-027 Package main_pkg SHALL hold mode enum, phase enum, lamp encodings, segment constants, duration bounds.
REQ-028 One sub-module seg7_decoder (4-bit digit in, 7-bit active-low out, 4'hF = blank) SHALL be instantiated four times.

Verification (TICK_DIV=1)
REQ-029 Reset release -> led1=001, led2=100, digits 40,12,40,78; after 5 ticks led1=010, led7_2=24.
REQ-030 14 ticks after reset -> back to P0, digits 0,5,0,7.
REQ-031 ChangeMode -> digits 7F, counters frozen; ChangeLight -> led1=010; ChangeMode -> AUTO at P0.
REQ-032 Config, Increase, ChangeLight, Increase, Confirm, Config -> AUTO with G=6,Y=3: led7_2=02, led7_3/led7_4 = 0,9.
REQ-033 CONFIG with G=1: Decrease keeps 1; Y=9: Increase keeps 9; Config without Confirm -> old G,Y.
REQ-034 Config and Increase asserted together -> mode change only, no value change.
